rpc_cmd_encoder: RTL and testbench

Builds 32-bit RPC DRAM command words from structured command requests and streams each word to the PHY as 16-bit beats. It sits between the controller's command scheduler and the PHY command path, and is the transmit-side counterpart of `rpc_cmd_decoder`. Every word it emits decodes back to the requested command class, burst length, ZQC mode and refresh bank mask.

---
 rtl/rpc_cmd_pkg.sv | 37 +++
 rtl/rpc_cmd_encoder_if.sv | 33 +++
 rtl/rpc_cmd_serializer.sv | 79 +++++++
 rtl/rpc_cmd_encoder.sv | 90 +++++++++
 tb/tb_rpc_cmd_encoder.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpc_cmd_pkg.sv
// Shared RPC DRAM command codes plus the encoder's opcode and field-position constants.
// CMD_* codes are the ones rpc_cmd_decoder reports, so both sides agree on the mapping.
package rpc_cmd_pkg;

  typedef logic [3:0] cmd_code_t;
  typedef logic [2:0] opc_t;

  localparam cmd_code_t CMD_INVALID = 4'd0;
  localparam cmd_code_t CMD_RD      = 4'd1;
  localparam cmd_code_t CMD_WR      = 4'd2;
  localparam cmd_code_t CMD_MRS     = 4'd3;
  localparam cmd_code_t CMD_PRE     = 4'd4;
  localparam cmd_code_t CMD_ACT     = 4'd5;
  localparam cmd_code_t CMD_REF     = 4'd6;
  localparam cmd_code_t CMD_ZQC     = 4'd7;
  localparam cmd_code_t CMD_RESET   = 4'd8;

  localparam opc_t OPC_RD  = 3'b000;
  localparam opc_t OPC_WR  = 3'b001;
  localparam opc_t OPC_MRS = 3'b010;
  localparam opc_t OPC_PRE = 3'b100;
  localparam opc_t OPC_ACT = 3'b101;
  localparam opc_t OPC_REF = 3'b110;
  localparam opc_t OPC_ZQC = 3'b001;

  localparam int unsigned OPC_LSB      = 16;
  localparam int unsigned OPC_W        = 3;
  localparam int unsigned BL_LSB       = 21;
  localparam int unsigned BL_W         = 6;
  localparam int unsigned REF_MASK_LSB = 22;
  localparam int unsigned REF_MASK_W   = 4;
  localparam int unsigned ZQC_LSB      = 30;
  localparam int unsigned ZQC_W        = 2;

  localparam logic [31:0] RESET_WORD = 32'h0000_0001;

endpackage

// File: rtl/rpc_cmd_encoder_if.sv
// Request and PHY beat-stream signals of rpc_cmd_encoder.
// slave = encoder side, master = scheduler/PHY side.
interface rpc_cmd_encoder_if #(
  parameter int unsigned DRAM_CMD_WIDTH = 32,
  parameter int unsigned BEAT_WIDTH     = 16
);

  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [3:0]                req_cmd_i;
  logic [5:0]                req_bl_i;
  logic [1:0]                req_zqc_mode_i;
  logic [3:0]                req_ref_mask_i;
  logic [DRAM_CMD_WIDTH-1:0] req_arg_i;
  logic                      cmd_valid_o;
  logic                      cmd_ready_i;
  logic [BEAT_WIDTH-1:0]     cmd_beat_o;
  logic                      cmd_last_o;
  logic                      err_o;

  modport slave (
    input  req_valid_i, req_cmd_i, req_bl_i, req_zqc_mode_i, req_ref_mask_i, req_arg_i,
    input  cmd_ready_i,
    output req_ready_o, cmd_valid_o, cmd_beat_o, cmd_last_o, err_o
  );

  modport master (
    output req_valid_i, req_cmd_i, req_bl_i, req_zqc_mode_i, req_ref_mask_i, req_arg_i,
    output cmd_ready_i,
    input  req_ready_o, cmd_valid_o, cmd_beat_o, cmd_last_o, err_o
  );

endinterface

// File: rtl/rpc_cmd_serializer.sv
// Holds an encoded command word and streams it LSB-first as BEAT_WIDTH beats.
// A new word may be loaded on the last-beat handshake so words go out without bubbles.
module rpc_cmd_serializer #(
  parameter int unsigned DRAM_CMD_WIDTH = 32,
  parameter int unsigned BEAT_WIDTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic [DRAM_CMD_WIDTH-1:0] word_i,
  input  logic                      cmd_ready_i,
  output logic                      ready_o,
  output logic                      cmd_valid_o,
  output logic [BEAT_WIDTH-1:0]     cmd_beat_o,
  output logic                      cmd_last_o
);

  localparam int unsigned NUM_BEATS = DRAM_CMD_WIDTH / BEAT_WIDTH;
  localparam int unsigned IdxW      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BEATS - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  logic [0:0]                state_d, state_q;
  logic [IdxW-1:0]           idx_d, idx_q;
  logic [DRAM_CMD_WIDTH-1:0] word_d, word_q;
  logic                      beat_hs;

  assign cmd_valid_o = (state_q == StSend);
  assign cmd_last_o  = cmd_valid_o && (idx_q == LastIdx);
  assign cmd_beat_o  = word_q[idx_q*BEAT_WIDTH +: BEAT_WIDTH];
  assign beat_hs     = cmd_valid_o && cmd_ready_i;
  // Ready is forced low during reset so nothing is accepted in the reset cycle.
  assign ready_o     = !rst_i && ((state_q == StIdle) || (beat_hs && cmd_last_o));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      StIdle: begin
        if (load_i) begin
          state_d = StSend;
          idx_d   = '0;
          word_d  = word_i;
        end
      end
      StSend: begin
        if (beat_hs) begin
          if (cmd_last_o) begin
            idx_d = '0;
            if (load_i) begin
              word_d = word_i;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: rtl/rpc_cmd_encoder.sv
// RPC DRAM command encoder: builds the 32-bit command word and hands it to the serializer.
// Define RPC_CMD_ENC_CHECK_EN to drop zero-BL RD/WR and zero-mask REF with an err_o pulse.
module rpc_cmd_encoder
  import rpc_cmd_pkg::*;
#(
  parameter int unsigned DRAM_CMD_WIDTH = 32,
  parameter int unsigned BEAT_WIDTH     = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  rpc_cmd_encoder_if.slave  bus
);

  logic [DRAM_CMD_WIDTH-1:0] word;
  opc_t                      opc;
  logic                      legal;
  logic                      ready;
  logic                      accept;

  // Non-owned positions pass req_arg_i through; owned fields overwrite it.
  always_comb begin
    word  = bus.req_arg_i;
    opc   = OPC_RD;
    legal = 1'b1;
    case (bus.req_cmd_i)
      CMD_RD:    opc = OPC_RD;
      CMD_WR:    opc = OPC_WR;
      CMD_MRS:   opc = OPC_MRS;
      CMD_PRE:   opc = OPC_PRE;
      CMD_ACT:   opc = OPC_ACT;
      CMD_REF:   opc = OPC_REF;
      CMD_ZQC:   opc = OPC_ZQC;
      CMD_RESET: opc = OPC_RD;
      default:   legal = 1'b0;
    endcase
    word[OPC_LSB +: OPC_W] = opc;
    word[0]                = (bus.req_cmd_i == CMD_ZQC);
    case (bus.req_cmd_i)
      CMD_RD, CMD_WR: word[BL_LSB +: BL_W] = bus.req_bl_i;
      CMD_REF:        word[REF_MASK_LSB +: REF_MASK_W] = bus.req_ref_mask_i;
      CMD_ZQC:        word[ZQC_LSB +: ZQC_W] = bus.req_zqc_mode_i;
      CMD_RESET:      word = DRAM_CMD_WIDTH'(RESET_WORD);
      default:        ;
    endcase
`ifdef RPC_CMD_ENC_CHECK_EN
    if (((bus.req_cmd_i == CMD_RD) || (bus.req_cmd_i == CMD_WR)) && (bus.req_bl_i == '0)) begin
      legal = 1'b0;
    end
    if ((bus.req_cmd_i == CMD_REF) && (bus.req_ref_mask_i == '0)) begin
      legal = 1'b0;
    end
`endif
  end

  assign accept          = bus.req_valid_i && ready;
  assign bus.req_ready_o = ready;

  rpc_cmd_serializer #(
    .DRAM_CMD_WIDTH(DRAM_CMD_WIDTH),
    .BEAT_WIDTH    (BEAT_WIDTH)
  ) u_serializer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept && legal),
    .word_i     (word),
    .cmd_ready_i(bus.cmd_ready_i),
    .ready_o    (ready),
    .cmd_valid_o(bus.cmd_valid_o),
    .cmd_beat_o (bus.cmd_beat_o),
    .cmd_last_o (bus.cmd_last_o)
  );

`ifdef RPC_CMD_ENC_CHECK_EN
  logic err_d, err_q;

  assign err_d     = accept && !legal;
  assign bus.err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rpc_cmd_encoder.sv
// Scoreboard bench for rpc_cmd_encoder: a reference encoder pushes expected beats and err
// pulses; an independent monitor pops and compares as the DUT presents them.
module tb_rpc_cmd_encoder;
  import rpc_cmd_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 16;
  localparam int unsigned NB = DW / BW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rpc_cmd_encoder_if #(.DRAM_CMD_WIDTH(DW), .BEAT_WIDTH(BW)) bus ();

  rpc_cmd_encoder #(.DRAM_CMD_WIDTH(DW), .BEAT_WIDTH(BW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready
  logic [BW:0] exp_q[$];
  int err_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference encoding computed from the field rules with plain masks and shifts.
  function automatic void model(input logic [3:0] cmd, input logic [5:0] bl,
                                input logic [1:0] zm, input logic [3:0] mk,
                                input logic [31:0] arg, output bit legal, output logic [31:0] w);
    logic [31:0] base;
    legal = cmd inside {CMD_RD, CMD_WR, CMD_MRS, CMD_PRE, CMD_ACT, CMD_REF, CMD_ZQC, CMD_RESET};
    base  = arg & ~32'h0007_0001;
    case (cmd)
      CMD_RD:    w = (base & ~32'h07E0_0000) | ({26'd0, bl} << 21);
      CMD_WR:    w = (base & ~32'h07E0_0000) | ({26'd0, bl} << 21) | 32'h0001_0000;
      CMD_MRS:   w = base | 32'h0002_0000;
      CMD_PRE:   w = base | 32'h0004_0000;
      CMD_ACT:   w = base | 32'h0005_0000;
      CMD_REF:   w = (base & ~32'h03C0_0000) | ({28'd0, mk} << 22) | 32'h0006_0000;
      CMD_ZQC:   w = (base & ~32'hC000_0000) | ({30'd0, zm} << 30) | 32'h0001_0001;
      CMD_RESET: w = 32'h0000_0001;
      default:   w = 32'h0;
    endcase
`ifdef RPC_CMD_ENC_CHECK_EN
    if (((cmd == CMD_RD || cmd == CMD_WR) && bl == 6'd0) || (cmd == CMD_REF && mk == 4'd0))
      legal = 0;
`endif
  endfunction

  task automatic issue(input logic [3:0] cmd, input logic [5:0] bl, input logic [1:0] zm,
                       input logic [3:0] mk, input logic [31:0] arg, input bit ovr,
                       input logic [31:0] ovr_word, output int acc);
    logic [31:0] w;
    bit legal;
    bit got;
    got = 0;
    acc = -1;
    bus.req_valid_i    = 1'b1;
    bus.req_cmd_i      = cmd;
    bus.req_bl_i       = bl;
    bus.req_zqc_mode_i = zm;
    bus.req_ref_mask_i = mk;
    bus.req_arg_i      = arg;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready_o === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: req_ready_o stayed low, required 1");
    end else begin
      acc = cyc;
      model(cmd, bl, zm, mk, arg, legal, w);
      if (ovr) w = ovr_word;
      if (legal) begin
        for (int k = 0; k < NB; k++) exp_q.push_back({1'(k == NB - 1), w[k*BW +: BW]});
      end else begin
`ifdef RPC_CMD_ENC_CHECK_EN
        err_q.push_back(cyc + 1);
`endif
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    @(posedge clk);
    #1;
  endtask

  // PHY ready generator, updated off the request-driving instant.
  initial begin
    bus.cmd_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.cmd_ready_i = 1'b1;
        1:       bus.cmd_ready_i = 1'($urandom_range(0, 1));
        default: bus.cmd_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: beats, err pulses and backpressure stability.
  initial begin
    bit stall;
    logic [BW-1:0] pb;
    logic pl;
    logic [BW:0] e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
        continue;
      end
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        chk("err_pulse", 64'(bus.err_o), 64'd1);
        void'(err_q.pop_front());
      end else if (bus.err_o !== 1'b0) begin
        chk("err_spurious", 64'(bus.err_o), 64'd0);
      end
      if (stall) begin
        chk("stall_valid", 64'(bus.cmd_valid_o), 64'd1);
        chk("stall_beat", 64'(bus.cmd_beat_o), 64'(pb));
        chk("stall_last", 64'(bus.cmd_last_o), 64'(pl));
      end
      if (bus.cmd_valid_o === 1'b1 && bus.cmd_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got beat %0h last %0b, required no beat",
                   bus.cmd_beat_o, bus.cmd_last_o);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(bus.cmd_beat_o), 64'(e[BW-1:0]));
          chk("beat_last", 64'(bus.cmd_last_o), 64'(e[BW]));
        end
      end
      stall = (bus.cmd_valid_o === 1'b1) && (bus.cmd_ready_i !== 1'b1);
      pb = bus.cmd_beat_o;
      pl = bus.cmd_last_o;
    end
  end

  initial begin
    int a1, a2, acc;
    logic [3:0] c;
    logic [5:0] bl;
    logic [3:0] mk;
    bus.req_valid_i    = 1'b0;
    bus.req_cmd_i      = '0;
    bus.req_bl_i       = '0;
    bus.req_zqc_mode_i = '0;
    bus.req_ref_mask_i = '0;
    bus.req_arg_i      = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.cmd_valid_o), 64'd0);
    chk("rst_beat", 64'(bus.cmd_beat_o), 64'd0);
    chk("rst_last", 64'(bus.cmd_last_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_ready_low", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk);
    #1;

    // RESET ignores every field
    issue(CMD_RESET, 6'($urandom), 2'($urandom), 4'($urandom), $urandom, 1, 32'h0000_0001, acc);
    wait_idle();

    // RD bl=8, first beat in the cycle after acceptance
    issue(CMD_RD, 6'd8, 2'd0, 4'd0, 32'h0, 1, 32'h0100_0000, acc);
    @(negedge clk);
    chk("latency_valid", 64'(bus.cmd_valid_o), 64'd1);
    wait_idle();

    // ZQC held under backpressure for 3 cycles on beat 0
    rdy_mode = 2;
    @(posedge clk);
    #1;
    issue(CMD_ZQC, 6'd0, 2'b10, 4'd0, 32'h0, 1, 32'h8001_0001, acc);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_beat", 64'(bus.cmd_beat_o), 64'h0001);
    end
    rdy_mode = 0;
    wait_idle();

    issue(CMD_REF, 6'd0, 2'd0, 4'hF, 32'h0, 1, 32'h03C6_0000, acc);
    wait_idle();

    // Back-to-back WR: second accepted on the first word's last beat
    issue(CMD_WR, 6'd5, 2'd0, 4'd0, $urandom, 0, 32'h0, a1);
    issue(CMD_WR, 6'd9, 2'd0, 4'd0, $urandom, 0, 32'h0, a2);
    chk("b2b_accept_cycle", 64'(a2), 64'(a1 + NB));
    wait_idle();

    // Dropped request
    issue(CMD_INVALID, 6'd3, 2'd1, 4'd2, $urandom, 0, 32'h0, acc);
    repeat (2) begin
      @(negedge clk);
      chk("invalid_no_valid", 64'(bus.cmd_valid_o), 64'd0);
    end
    @(posedge clk);
    #1;

`ifdef RPC_CMD_ENC_CHECK_EN
    issue(CMD_REF, 6'd0, 2'd0, 4'd0, 32'h0, 0, 32'h0, acc);
    @(negedge clk);
    chk("ref0_dropped", 64'(bus.cmd_valid_o), 64'd0);
    @(posedge clk);
    #1;
`else
    issue(CMD_REF, 6'd0, 2'd0, 4'd0, 32'h0, 1, 32'h0006_0000, acc);
`endif
    wait_idle();

    // Reset right after beat 0's handshake abandons beat 1
    issue(CMD_RD, 6'd4, 2'd0, 4'd0, $urandom, 0, 32'h0, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready_low", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    err_q.delete();
    @(negedge clk);
    chk("midrst_valid", 64'(bus.cmd_valid_o), 64'd0);
    chk("midrst_beat", 64'(bus.cmd_beat_o), 64'd0);
    @(posedge clk);
    #1;
    issue(CMD_MRS, 6'd0, 2'd0, 4'd0, $urandom, 0, 32'h0, acc);
    wait_idle();

    // Randomized traffic under random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      c  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 8)) : 4'($urandom);
      bl = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      mk = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      issue(c, bl, 2'($urandom), mk, $urandom, 0, 32'h0, acc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    wait_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_beats", 64'(exp_q.size()), 64'd0);
    chk("drain_err", 64'(err_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
